// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: word, RAM handshake and arbiter state types shared by the RAM, caches and arbiter
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between instruction fetch (I) and data (D) requesters,
// with I starvation protection and a watchdog on RAM stalls
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t    state, next_state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          d_req, ok, done;

    assign d_req = dREN | dWEN;
    assign ok    = ramstate == ACCESS;
    assign done  = ok || ramstate == ERROR || tmo_cnt == TW'(TIMEOUT);

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!iREN || next_state == IGRANT)
                starve_cnt <= '0;
            else if (next_state == DGRANT && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Every grant is preceded by an IDLE cycle, so clearing there covers grant entry
    always_ff @(posedge CLK) begin
        if (!nRST || state == IDLE) tmo_cnt <= '0;
        else                        tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = iREN;
        dwait      = d_req;
        iload      = '0;
        dload      = '0;
        err        = 1'b0;
        case (state)
            IDLE: next_state = (d_req && (starve_cnt < SW'(STARVE_MAX) || !iREN)) ? DGRANT :
                               iREN ? IGRANT : IDLE;
            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (done) begin
                        iwait      = 1'b0;
                        iload      = ok ? ramload : '0;
                        err        = !ok;
                        next_state = IDLE;
                    end
                end
            end
            DGRANT: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (done) begin
                        dwait      = 1'b0;
                        dload      = ok ? ramload : '0;
                        err        = !ok;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench with a RAM model and a per-cycle behavioural reference of the arbiter
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE = 4;
    localparam int TMO    = 255;

    logic      CLK = 1'b0;
    logic      nRST = 1'b0;
    logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    word_t     iaddr = '0, daddr = '0, dstore = '0;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    logic      iwait, dwait, ramREN, ramWEN, err;
    ramstate_t ramstate;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:255] = '{default: '0};
    int          lat = 1;
    int          mode = 0;
    int          ram_cnt = 0;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a = '0;
    word_t       pre_d = '0;

    ram_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    // RAM model: mode 0 = ACCESS after lat BUSY cycles, 1 = stuck BUSY, 2 = ERROR
    assign ramload = mem[ramaddr[7:0]];
    always_comb begin
        ramstate = FREE;
        if (ramREN || ramWEN)
            ramstate = (mode == 1) ? BUSY : (mode == 2) ? ERROR : (ram_cnt < lat) ? BUSY : ACCESS;
    end
    always @(posedge CLK) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (ramWEN && ramstate == ACCESS) mem[ramaddr[7:0]] <= ramstore;
        if (!(ramREN || ramWEN)) ram_cnt <= 0;
        else if (ramstate == BUSY) ram_cnt <= ram_cnt + 1;
    end

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: owner 0 = none, 1 = I, 2 = D; waited = grant cycles without a result
    int owner = 0, waited = 0, streak = 0;
    initial begin
        @(posedge CLK);
        forever begin
            logic dq, fin, good, e_ren, e_wen, e_iw, e_dw, e_err;
            word_t e_addr, e_store, e_il, e_dl;
            @(negedge CLK);
            dq = dREN | dWEN;
            good = ramstate == ACCESS;
            fin = good || ramstate == ERROR || waited >= TMO;
            e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
            e_iw = iREN; e_dw = dq; e_il = 0; e_dl = 0; e_err = 0;
            if (owner == 1 && iREN) begin
                e_ren = 1; e_addr = iaddr;
                if (fin) begin e_iw = 0; e_il = good ? mem[iaddr[7:0]] : 0; e_err = !good; end
            end else if (owner == 2 && dq) begin
                e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
                if (fin) begin e_dw = 0; e_dl = good ? mem[daddr[7:0]] : 0; e_err = !good; end
            end
            cmp("m_ramREN", 32'(ramREN), 32'(e_ren));
            cmp("m_ramWEN", 32'(ramWEN), 32'(e_wen));
            cmp("m_ramaddr", ramaddr, e_addr);
            cmp("m_ramstore", ramstore, e_store);
            cmp("m_iwait", 32'(iwait), 32'(e_iw));
            cmp("m_dwait", 32'(dwait), 32'(e_dw));
            cmp("m_iload", iload, e_il);
            cmp("m_dload", dload, e_dl);
            cmp("m_err", 32'(err), 32'(e_err));
            if (!nRST) begin
                owner = 0; waited = 0; streak = 0;
            end else if (owner != 0) begin
                if (!(owner == 1 ? iREN : dq) || fin) owner = 0;
                else waited++;
            end else if (dq && (streak < STARVE || !iREN)) begin
                owner = 2; waited = 0;
                streak = iREN ? ((streak < STARVE) ? streak + 1 : STARVE) : 0;
            end else if (iREN) begin
                owner = 1; waited = 0; streak = 0;
            end else begin
                streak = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input bit is_i, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((is_i ? iwait : dwait) && n < 400);
        if (n >= 400) cmp(is_i ? "i_timeout" : "d_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n, c, run, max_run;
        logic [9:0] seq;
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c, run, max_run;
        logic [9:0] seq;
        pre_we = 1; pre_a = 8'h40; pre_d = 32'hDEADBEEF;
        cyc();
        pre_we = 0;
        cyc();
        nRST = 1;
        @(negedge CLK);
        cmp("rst_state", 32'(dut.state), 32'(IDLE));
        cmp("rst_ramREN", 32'(ramREN), 0);
        cmp("rst_iwait", 32'(iwait), 0);
        cmp("rst_err", 32'(err), 0);

        // 1: I read, two BUSY then ACCESS
        cyc();
        lat = 2; iREN = 1; iaddr = 32'h40;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            cmp("t1_iwait_hi", 32'(iwait), 1);
        end
        @(negedge CLK);
        cmp("t1_iwait_lo", 32'(iwait), 0);
        cmp("t1_iload", iload, 32'hDEADBEEF);
        cyc();
        iREN = 0;
        @(negedge CLK);
        cmp("t1_idle", 32'(dut.state), 32'(IDLE));

        // 2: D write then I readback
        cyc();
        lat = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
        cyc();
        @(negedge CLK);
        cmp("t2_ramWEN", 32'(ramWEN), 1);
        cmp("t2_ramaddr", ramaddr, 32'h80);
        cmp("t2_ramstore", ramstore, 32'h12345678);
        wait_done(0, n);
        cyc();
        dWEN = 0; iREN = 1; iaddr = 32'h80;
        wait_done(1, n);
        cmp("t2_readback", iload, 32'h12345678);
        cyc();
        iREN = 0;

        // 3: contention, starvation guard
        cyc();
        iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h80;
        c = 0; n = 0; seq = '0;
        while (c < 10 && n < 200) begin
            @(negedge CLK);
            n++;
            if (!iwait) begin seq = {seq[8:0], 1'b1}; c++; end
            if (!dwait) begin seq = {seq[8:0], 1'b0}; c++; end
        end
        cmp("t3_order", 32'(seq), 32'b0000100001);
        run = 0; max_run = 0;
        for (int i = 9; i >= 0; i--) begin
            run = seq[i] ? 0 : run + 1;
            if (run > max_run) max_run = run;
        end
        cmp("t3_max_d_run", 32'(max_run), 32'd4);
        cyc();
        iREN = 0; dREN = 0;

        // 4: stuck BUSY during D read -> watchdog abort
        cyc();
        mode = 1; dREN = 1; daddr = 32'h80;
        wait_done(0, n);
        cmp("t4_cycles", 32'(n), 32'd257);
        cmp("t4_dload", dload, 0);
        cmp("t4_err", 32'(err), 1);
        cyc();
        dREN = 0; mode = 0;
        @(negedge CLK);
        cmp("t4_err_off", 32'(err), 0);
        cmp("t4_idle", 32'(dut.state), 32'(IDLE));

        // 5: ERROR during I read, then a normal D read
        cyc();
        mode = 2; iREN = 1; iaddr = 32'h40;
        cyc();
        @(negedge CLK);
        cmp("t5_iwait", 32'(iwait), 0);
        cmp("t5_iload", iload, 0);
        cmp("t5_err", 32'(err), 1);
        cyc();
        iREN = 0; mode = 0; dREN = 1; daddr = 32'h80;
        wait_done(0, n);
        cmp("t5_dload", dload, 32'h12345678);
        cmp("t5_d_err", 32'(err), 0);
        cyc();
        dREN = 0;

        // 6: reset while in DGRANT, then the write is re-issued
        cyc();
        lat = 5; dWEN = 1; daddr = 32'h90; dstore = 32'hCAFEF00D;
        cyc();
        @(negedge CLK);
        cmp("t6_grant", 32'(ramWEN), 1);
        cyc();
        nRST = 0;
        cyc();
        nRST = 1;
        @(negedge CLK);
        cmp("t6_ramWEN", 32'(ramWEN), 0);
        cmp("t6_ramREN", 32'(ramREN), 0);
        cmp("t6_state", 32'(dut.state), 32'(IDLE));
        cmp("t6_err", 32'(err), 0);
        wait_done(0, n);
        cmp("t6_wr_err", 32'(err), 0);
        cyc();
        dWEN = 0; dREN = 1;
        wait_done(0, n);
        cmp("t6_readback", dload, 32'hCAFEF00D);
        cyc();
        dREN = 0;
        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
